// File: rtl/ext_ipa_pkg.sv
// ext_ipa_pkg: shared AR field widths, burst encoding and pointer sizing for the external-unit AR buffer
package ext_ipa_pkg;
  localparam int AR_FIXED_W = 29;
  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/ext_fifo_mem_ipa.sv
// ext_fifo_mem_ipa: DATA_WIDTH x DEPTH register array with one write port and an asynchronous read port
module ext_fifo_mem_ipa #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                     clk_i,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // storage is deliberately unreset; only valid entries are ever read out
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/ext_ar_fifo_ipa.sv
// ext_ar_fifo_ipa: AXI4 AR buffer with outstanding-read limiter; EXT_AR_FIFO_IPA_FALLTHROUGH_EN enables empty-FIFO bypass
module ext_ar_fifo_ipa
  import ext_ipa_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int USER_WIDTH = 6,
  parameter int DEPTH      = 4,
  parameter int MAX_OUTST  = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             slave_valid_i,
  input  logic [ADDR_WIDTH-1:0]            slave_addr_i,
  input  logic [2:0]                       slave_prot_i,
  input  logic [3:0]                       slave_region_i,
  input  logic [7:0]                       slave_len_i,
  input  logic [2:0]                       slave_size_i,
  input  logic [1:0]                       slave_burst_i,
  input  logic                             slave_lock_i,
  input  logic [3:0]                       slave_cache_i,
  input  logic [3:0]                       slave_qos_i,
  input  logic [ID_WIDTH-1:0]              slave_id_i,
  input  logic [USER_WIDTH-1:0]            slave_user_i,
  output logic                             slave_ready_o,
  output logic                             master_valid_o,
  output logic [ADDR_WIDTH-1:0]            master_addr_o,
  output logic [2:0]                       master_prot_o,
  output logic [3:0]                       master_region_o,
  output logic [7:0]                       master_len_o,
  output logic [2:0]                       master_size_o,
  output logic [1:0]                       master_burst_o,
  output logic                             master_lock_o,
  output logic [3:0]                       master_cache_o,
  output logic [3:0]                       master_qos_o,
  output logic [ID_WIDTH-1:0]              master_id_o,
  output logic [USER_WIDTH-1:0]            master_user_o,
  input  logic                             master_ready_i,
  input  logic                             r_last_i,
  output logic [$clog2(DEPTH+1)-1:0]       fill_o,
  output logic [$clog2(MAX_OUTST+1)-1:0]   outst_o,
  output logic                             err_o
);
  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int DW = AR_FIXED_W + ADDR_WIDTH + USER_WIDTH + ID_WIDTH;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0] s_data, rd_data, m_data;
  logic empty, full, issue_ok, bypass, hs, push, pop;
  assign s_data = {slave_cache_i, slave_prot_i, slave_lock_i, slave_burst_i, slave_size_i,
                   slave_len_i, slave_qos_i, slave_region_i, slave_addr_i, slave_user_i, slave_id_i};
  assign {master_cache_o, master_prot_o, master_lock_o, master_burst_o, master_size_o,
          master_len_o, master_qos_o, master_region_o, master_addr_o, master_user_o, master_id_o} = m_data;
  assign empty    = wr_ptr == rd_ptr;
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) & (wr_ptr[AW] != rd_ptr[AW]);
  assign issue_ok = outst_o < CW'(MAX_OUTST);
`ifdef EXT_AR_FIFO_IPA_FALLTHROUGH_EN
  assign bypass = empty & issue_ok;
`else
  assign bypass = 1'b0;
`endif
  assign slave_ready_o  = rst_ni & !full;
  assign master_valid_o = rst_ni & (bypass ? slave_valid_i : !empty & issue_ok);
  assign m_data         = bypass ? s_data : rd_data;
  assign hs             = master_valid_o & master_ready_i;
  assign push           = slave_valid_i & slave_ready_o & !(bypass & master_ready_i);
  assign pop            = hs & !bypass;
  assign fill_o         = wr_ptr - rd_ptr;
  ext_fifo_mem_ipa #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) u_mem (
    .clk_i (clk_i),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (s_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );
  // write/read pointers advance on accepted push and consumed pop
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  // in-flight counter: issue adds, RLAST retires; a stray RLAST at zero latches the error
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      outst_o <= '0;
      err_o   <= 1'b0;
    end else begin
      outst_o <= (hs & !r_last_i) ? outst_o + 1'b1 :
                 (r_last_i & !hs & outst_o != '0) ? outst_o - 1'b1 : outst_o;
      err_o   <= err_o | (r_last_i & !hs & outst_o == '0);
    end
  end
endmodule

// File: tb/tb_ext_ar_fifo_ipa.sv
// tb_ext_ar_fifo_ipa: directed self-checking bench for ext_ar_fifo_ipa (DEPTH=4, MAX_OUTST=2)
module tb_ext_ar_fifo_ipa;
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic rst_ni, slave_valid_i, slave_ready_o, master_valid_o, master_ready_i, r_last_i, err_o;
  logic [31:0] slave_addr_i, master_addr_o;
  logic [2:0] slave_prot_i, master_prot_o, slave_size_i, master_size_o;
  logic [3:0] slave_region_i, master_region_o, slave_cache_i, master_cache_o, slave_qos_i, master_qos_o;
  logic [7:0] slave_len_i, master_len_o;
  logic [1:0] slave_burst_i, master_burst_o;
  logic slave_lock_i, master_lock_o;
  logic [3:0] slave_id_i, master_id_o;
  logic [5:0] slave_user_i, master_user_o;
  logic [2:0] fill_o;
  logic [1:0] outst_o;
  int n_chk = 0;
  int n_fail = 0;
  ext_ar_fifo_ipa #(.ID_WIDTH(4), .ADDR_WIDTH(32), .USER_WIDTH(6), .DEPTH(4), .MAX_OUTST(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .slave_valid_i(slave_valid_i), .slave_addr_i(slave_addr_i), .slave_prot_i(slave_prot_i),
    .slave_region_i(slave_region_i), .slave_len_i(slave_len_i), .slave_size_i(slave_size_i),
    .slave_burst_i(slave_burst_i), .slave_lock_i(slave_lock_i), .slave_cache_i(slave_cache_i),
    .slave_qos_i(slave_qos_i), .slave_id_i(slave_id_i), .slave_user_i(slave_user_i),
    .slave_ready_o(slave_ready_o), .master_valid_o(master_valid_o), .master_addr_o(master_addr_o),
    .master_prot_o(master_prot_o), .master_region_o(master_region_o), .master_len_o(master_len_o),
    .master_size_o(master_size_o), .master_burst_o(master_burst_o), .master_lock_o(master_lock_o),
    .master_cache_o(master_cache_o), .master_qos_o(master_qos_o), .master_id_o(master_id_o),
    .master_user_o(master_user_o), .master_ready_i(master_ready_i), .r_last_i(r_last_i),
    .fill_o(fill_o), .outst_o(outst_o), .err_o(err_o)
  );
  function automatic logic [70:0] exp_ar(input logic [31:0] a);
    return {~a[7:4], a[6:4], a[4], a[5:4], a[6:4] ^ 3'b101, a[11:4], a[8:5], a[7:4], a, a[9:4], a[7:4] + 4'h3};
  endfunction
  function automatic logic [70:0] obs_ar();
    return {master_cache_o, master_prot_o, master_lock_o, master_burst_o, master_size_o, master_len_o,
            master_qos_o, master_region_o, master_addr_o, master_user_o, master_id_o};
  endfunction
  task automatic drive(input logic [31:0] a);
    slave_addr_i   = a;
    slave_prot_i   = a[6:4];
    slave_region_i = a[7:4];
    slave_len_i    = a[11:4];
    slave_size_i   = a[6:4] ^ 3'b101;
    slave_burst_i  = a[5:4];
    slave_lock_i   = a[4];
    slave_cache_i  = ~a[7:4];
    slave_qos_i    = a[8:5];
    slave_id_i     = a[7:4] + 4'h3;
    slave_user_i   = a[9:4];
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  initial begin
    rst_ni = 1'b0; slave_valid_i = 1'b1; master_ready_i = 1'b0; r_last_i = 1'b0;
    drive(32'h0);
    repeat (3) tick();
    chk("rst_sready", slave_ready_o, 0);
    chk("rst_mvalid", master_valid_o, 0);
    chk("rst_fill", fill_o, 0);
    chk("rst_outst", outst_o, 0);
    chk("rst_err", err_o, 0);
    rst_ni = 1'b1; slave_valid_i = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(32'h100 + 32'(i) * 32'h10);
      slave_valid_i = 1'b1;
      #1;
      chk("push_ready", slave_ready_o, (i < 4) ? 1 : 0);
      tick();
    end
    chk("full_fill", fill_o, 4);
    master_ready_i = 1'b1; r_last_i = 1'b1;
    #1;
    chk("full_sready", slave_ready_o, 0);
    chk("pop0_valid", master_valid_o, 1);
    chk("pop0_ar", obs_ar(), exp_ar(32'h100));
    tick();
    chk("pop_only_fill", fill_o, 3);
    chk("pushpop_sready", slave_ready_o, 1);
    chk("pop1_ar", obs_ar(), exp_ar(32'h110));
    tick();
    chk("pushpop_fill", fill_o, 3);
    slave_valid_i = 1'b0;
    for (int j = 2; j < 5; j++) begin
      #1;
      chk("drain_valid", master_valid_o, 1);
      chk("drain_ar", obs_ar(), exp_ar(32'h100 + 32'(j) * 32'h10));
      tick();
    end
    chk("drained_fill", fill_o, 0);
    chk("drained_valid", master_valid_o, 0);
    chk("drained_outst", outst_o, 0);
    chk("drained_err", err_o, 0);
    master_ready_i = 1'b0; r_last_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h200 + 32'(i) * 32'h10);
      slave_valid_i = 1'b1;
      tick();
    end
    slave_valid_i = 1'b0;
    chk("lim_fill3", fill_o, 3);
    master_ready_i = 1'b1;
    #1;
    chk("lim_ar0", obs_ar(), exp_ar(32'h200));
    tick();
    chk("lim_outst1", outst_o, 1);
    chk("lim_ar1", obs_ar(), exp_ar(32'h210));
    tick();
    chk("lim_outst2", outst_o, 2);
    chk("lim_held", master_valid_o, 0);
    chk("lim_fill1", fill_o, 1);
    tick();
    chk("lim_still_held", master_valid_o, 0);
    r_last_i = 1'b1;
    tick();
    r_last_i = 1'b0;
    chk("retire_outst", outst_o, 1);
    #1;
    chk("third_valid", master_valid_o, 1);
    chk("third_ar", obs_ar(), exp_ar(32'h220));
    tick();
    chk("third_outst", outst_o, 2);
    chk("third_fill", fill_o, 0);
    master_ready_i = 1'b0; r_last_i = 1'b1;
    tick();
    r_last_i = 1'b0;
    chk("pre_same_outst", outst_o, 1);
    drive(32'h300); slave_valid_i = 1'b1;
    tick();
    slave_valid_i = 1'b0;
    chk("same_fill", fill_o, 1);
    master_ready_i = 1'b1; r_last_i = 1'b1;
    #1;
    chk("same_valid", master_valid_o, 1);
    tick();
    chk("same_outst", outst_o, 1);
    chk("same_err", err_o, 0);
    master_ready_i = 1'b0;
    tick();
    chk("last_outst0", outst_o, 0);
    chk("last_err0", err_o, 0);
    tick();
    r_last_i = 1'b0;
    chk("stray_err", err_o, 1);
    chk("stray_outst", outst_o, 0);
    drive(32'h400); slave_valid_i = 1'b1; master_ready_i = 1'b1;
    #1;
`ifdef EXT_AR_FIFO_IPA_FALLTHROUGH_EN
    chk("ft_valid", master_valid_o, 1);
    chk("ft_ar", obs_ar(), exp_ar(32'h400));
    tick();
    slave_valid_i = 1'b0;
    chk("ft_fill", fill_o, 0);
`else
    chk("reg_valid0", master_valid_o, 0);
    tick();
    slave_valid_i = 1'b0;
    #1;
    chk("reg_fill1", fill_o, 1);
    chk("reg_valid1", master_valid_o, 1);
    chk("reg_ar", obs_ar(), exp_ar(32'h400));
    tick();
    chk("reg_fill0", fill_o, 0);
`endif
    chk("lat_outst", outst_o, 1);
    chk("sticky_err", err_o, 1);
    master_ready_i = 1'b0;
    drive(32'h500); slave_valid_i = 1'b1;
    tick();
    chk("mid_fill", fill_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_sready", slave_ready_o, 0);
    chk("mid_rst_mvalid", master_valid_o, 0);
    tick();
    rst_ni = 1'b1; slave_valid_i = 1'b0;
    #1;
    chk("post_rst_fill", fill_o, 0);
    chk("post_rst_outst", outst_o, 0);
    chk("post_rst_err", err_o, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
